gamma_result_demux: RTL and testbench
=====================================

Name: gamma_result_demux

Overview:
- Downstream of the multiplexed column. The column processes the networks' inputs time-multiplexed, one network per gamma cycle.
- This block converts the column's raw output_spikes into one spike-time result per gamma cycle per output neuron.
- Each result is tagged with the network that owned that gamma cycle, a winner index is computed, and results queue in a small FIFO behind a valid/ready handshake for the readout logic.

Parameters:
- Q, 2, number of column output neurons.
- NNET, 2, number of multiplexed networks; network id rotates 0..NNET-1.
- TRES, 3, spike-time width; TMAX = 2^TRES-1 encodes "no spike".
- DEPTH, 2, result FIFO entries (>=1).

Ports:
- clk  input  1  system clock.
- rstb  input  1  asynchronous active-low reset.
- grst  input  1  gamma reset pulse; the cycle where it is high closes the current gamma window.
- output_spikes  input  Q  column output spikes for the current cycle.
- res_ready  input  1  consumer accepts head result.
- res_valid  output  1  FIFO non-empty.
- res_net  output  max(1,$clog2(NNET))  network id of head result.
- res_times  output  Q*TRES  per-neuron first-spike time, packed [Q-1:0][TRES-1:0].
- res_any  output  1  at least one neuron spiked in that gamma.
- res_winner  output  max(1,$clog2(Q))  index of earliest spiking neuron.
- overflow  output  1  sticky: a result was dropped.
- cur_net  output  max(1,$clog2(NNET))  network id of the gamma cycle in progress.

Behaviour:
- Reset (rstb low, async) clears:
  - time counter, capture registers (all neurons = TMAX), cur_net = 0, FIFO empty, overflow = 0.
  - All res_* outputs = 0 while empty.
- Time counter t:
  - 0 in the first cycle after grst or reset.
  - Increments each cycle grst is low.
  - Saturates at TMAX-1.
- Capture:
  - In a non-grst cycle, when output_spikes[q]=1 and captured[q]==TMAX, captured[q] <= t.
  - Later spikes of q in the same gamma are ignored.
  - Spikes in the grst cycle are ignored.
- Commit on a grst cycle:
  - Compute winner: the minimum captured time among neurons != TMAX; ties go to the lowest index.
  - res_any = any captured != TMAX. If res_any=0, winner = 0.
  - Push {cur_net, captured[], res_any, winner} into the FIFO.
  - Next cycle: captured all = TMAX, t = 0, cur_net = (cur_net+1) mod NNET.
  - A result is pushed every gamma, including empty ones.
- FIFO:
  - Registered. Pushed entry is visible on the outputs the cycle after the grst edge when the FIFO was empty.
  - Pop when res_valid && res_ready.
  - Outputs show the head entry; all res_* outputs = 0 when empty.
- Full:
  - Push without a simultaneous pop drops the new result and sets overflow=1, held until rstb.
  - Push with a simultaneous pop while full succeeds with no drop.
- Empty: res_ready is ignored and no pop occurs.
- Back-to-back grst (consecutive cycles): each cycle is a separate commit. The second commit carries an empty result (all TMAX, res_any=0) and cur_net advances twice.
- Pointers wrap modulo DEPTH; occupancy counter width $clog2(DEPTH+1).

Optional Feature:
- Macro: GAMMA_SPIKE_COUNT_EN.
- Defined:
  - Adds output port res_counts [Q-1:0][TRES-1:0].
  - Per-neuron count of spike cycles in the gamma window, saturating at TMAX, excluding the grst cycle.
  - Cleared at commit; stored in the FIFO with the result; 0 when empty.
- Undefined: port and count storage are absent; all other behaviour is identical.

Test Plan:
- Reset then idle, no grst -> res_valid=0, overflow=0, cur_net=0, all res_* = 0.
- Q=2. After grst, neuron1 spikes at t=2 and neuron0 at t=4. Next grst -> one cycle later: res_valid=1, res_net=0, res_times={4,2} (neuron0=4, neuron1=2), res_winner=1, res_any=1; cur_net=1.
- Neuron0 and neuron1 both spike at t=3, with neuron0 spiking again at t=5. Commit -> times {3,3}, winner=0. With GAMMA_SPIKE_COUNT_EN: counts neuron0=2, neuron1=1.
- Gamma with no spikes -> res_times all 7 (TRES=3), res_any=0, winner=0. Spike at t>=6 -> recorded 6 (saturated).
- res_ready held 0, three grst commits with DEPTH=2 -> entries for net 0 and net 1 kept, third dropped, overflow=1. Raise res_ready -> pops in order net0, net1; overflow stays 1.
- Full FIFO, grst and res_ready in the same cycle -> no drop, occupancy stays 2, overflow stays 0. Assert rstb low mid-gamma -> all outputs 0 immediately.

Source files
------------

// File: rtl/gamma_result_demux.sv
// gamma_result_demux
//   Turns the multiplexed column's raw output_spikes into one first-spike-time
//   result per gamma window. Each result is tagged with the network that
//   owned the window and carries a winner index (the earliest spiking neuron).
//   Results are queued in a small registered FIFO behind a valid/ready
//   handshake.
//
// Optional feature macro: GAMMA_SPIKE_COUNT_EN
//   When this macro is defined, the block adds the res_counts port. It holds a
//   per-neuron count of spike cycles in each window, saturating at TMAX.
//
// Ports
//   clk           system clock
//   rstb          asynchronous active-low reset
//   grst          gamma reset pulse; its cycle closes (commits) the window
//   output_spikes per-neuron spikes for the current cycle
//   res_ready     consumer accepts the head result
//   res_valid     FIFO non-empty
//   res_net       network id of the head result
//   res_times     per-neuron first-spike time, TMAX = no spike
//   res_any       at least one neuron spiked in that window
//   res_winner    index of the earliest spiking neuron (lowest index on ties)
//   overflow      sticky: a result was dropped because the FIFO was full
//   cur_net       network id of the window in progress
//   res_counts    per-neuron spike-cycle counts (GAMMA_SPIKE_COUNT_EN only)
module gamma_result_demux #(
  parameter int Q     = 2,
  parameter int NNET  = 2,
  parameter int TRES  = 3,
  parameter int DEPTH = 2,
  localparam int NW   = (NNET > 1) ? $clog2(NNET) : 1,
  localparam int QW   = (Q > 1) ? $clog2(Q) : 1,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      grst,
  input  logic [Q-1:0]              output_spikes,
  input  logic                      res_ready,
  output logic                      res_valid,
  output logic [NW-1:0]             res_net,
  output logic [Q-1:0][TRES-1:0]    res_times,
  output logic                      res_any,
  output logic [QW-1:0]             res_winner,
  output logic                      overflow,
  output logic [NW-1:0]             cur_net
`ifdef GAMMA_SPIKE_COUNT_EN
  ,
  output logic [Q-1:0][TRES-1:0]    res_counts
`endif
);

  localparam logic [TRES-1:0] TMAX = '1;

  logic [TRES-1:0]          t_q, t_d;
  logic [Q-1:0][TRES-1:0]   cap_q, cap_d;
  logic [NW-1:0]            cur_net_q, cur_net_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            occ_q, occ_d;
  logic                     ovf_q, ovf_d;

  logic [NW-1:0]            mem_net_q   [DEPTH];
  logic [NW-1:0]            mem_net_d   [DEPTH];
  logic [Q-1:0][TRES-1:0]   mem_times_q [DEPTH];
  logic [Q-1:0][TRES-1:0]   mem_times_d [DEPTH];
  logic                     mem_any_q   [DEPTH];
  logic                     mem_any_d   [DEPTH];
  logic [QW-1:0]            mem_win_q   [DEPTH];
  logic [QW-1:0]            mem_win_d   [DEPTH];

  logic                     win_any;
  logic [QW-1:0]            win_idx;
  logic [TRES-1:0]          win_best;
  logic                     full, pop, do_push;

`ifdef GAMMA_SPIKE_COUNT_EN
  logic [Q-1:0][TRES-1:0]   cnt_q, cnt_d;
  logic [Q-1:0][TRES-1:0]   mem_cnt_q [DEPTH];
  logic [Q-1:0][TRES-1:0]   mem_cnt_d [DEPTH];
`endif

  // Window timing, first-spike capture, and network rotation.
  always_comb begin
    t_d       = t_q;
    cap_d     = cap_q;
    cur_net_d = cur_net_q;
    if (grst) begin
      t_d       = '0;
      cap_d     = '1;  // every neuron back to TMAX
      cur_net_d = (cur_net_q == NW'(NNET - 1)) ? '0 : cur_net_q + 1'b1;
    end else begin
      if (t_q != TMAX - 1'b1) t_d = t_q + 1'b1;
      for (int unsigned i = 0; i < Q; i++) begin
        if (output_spikes[i] && cap_q[i] == TMAX) cap_d[i] = t_q;
      end
    end
  end

`ifdef GAMMA_SPIKE_COUNT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (grst) begin
      cnt_d = '0;
    end else begin
      for (int unsigned i = 0; i < Q; i++) begin
        if (output_spikes[i] && cnt_q[i] != TMAX) cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end
`endif

  // Earliest captured time wins; a strict compare keeps the lowest index on ties.
  always_comb begin
    win_any  = 1'b0;
    win_idx  = '0;
    win_best = TMAX;
    for (int unsigned i = 0; i < Q; i++) begin
      if (cap_q[i] != TMAX) begin
        win_any = 1'b1;
        if (cap_q[i] < win_best) begin
          win_best = cap_q[i];
          win_idx  = QW'(i);
        end
      end
    end
  end

  // FIFO control. When the FIFO is full, a push is still accepted if a pop
  // happens in the same cycle. In that case the write lands on the slot that
  // is being vacated.
  always_comb begin
    full      = (occ_q == CW'(DEPTH));
    pop       = res_valid && res_ready;
    do_push   = grst && (!full || pop);
    ovf_d     = ovf_q | (grst && full && !pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    mem_net_d   = mem_net_q;
    mem_times_d = mem_times_q;
    mem_any_d   = mem_any_q;
    mem_win_d   = mem_win_q;
`ifdef GAMMA_SPIKE_COUNT_EN
    mem_cnt_d   = mem_cnt_q;
`endif
    if (do_push) begin
      mem_net_d[wr_ptr_q]   = cur_net_q;
      mem_times_d[wr_ptr_q] = cap_q;
      mem_any_d[wr_ptr_q]   = win_any;
      mem_win_d[wr_ptr_q]   = win_idx;
`ifdef GAMMA_SPIKE_COUNT_EN
      mem_cnt_d[wr_ptr_q]   = cnt_q;
`endif
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (do_push && !pop)      occ_d = occ_q + 1'b1;
    else if (!do_push && pop) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      t_q       <= '0;
      cap_q     <= '1;
      cur_net_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      ovf_q     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_net_q[i]   <= '0;
        mem_times_q[i] <= '0;
        mem_any_q[i]   <= 1'b0;
        mem_win_q[i]   <= '0;
      end
    end else begin
      t_q         <= t_d;
      cap_q       <= cap_d;
      cur_net_q   <= cur_net_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      ovf_q       <= ovf_d;
      mem_net_q   <= mem_net_d;
      mem_times_q <= mem_times_d;
      mem_any_q   <= mem_any_d;
      mem_win_q   <= mem_win_d;
    end
  end

`ifdef GAMMA_SPIKE_COUNT_EN
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_cnt_q[i] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end
`endif

  always_comb begin
    res_valid  = (occ_q != '0);
    res_net    = res_valid ? mem_net_q[rd_ptr_q]   : '0;
    res_times  = res_valid ? mem_times_q[rd_ptr_q] : '0;
    res_any    = res_valid ? mem_any_q[rd_ptr_q]   : 1'b0;
    res_winner = res_valid ? mem_win_q[rd_ptr_q]   : '0;
`ifdef GAMMA_SPIKE_COUNT_EN
    res_counts = res_valid ? mem_cnt_q[rd_ptr_q]   : '0;
`endif
    overflow   = ovf_q;
    cur_net    = cur_net_q;
  end

endmodule

// File: tb/tb_gamma_result_demux.sv
module tb_gamma_result_demux;

  logic            clk = 1'b0;
  logic            rstb;
  logic            grst;
  logic [1:0]      output_spikes;
  logic            res_ready;
  logic            res_valid;
  logic [0:0]      res_net;
  logic [1:0][2:0] res_times;
  logic            res_any;
  logic [0:0]      res_winner;
  logic            overflow;
  logic [0:0]      cur_net;
`ifdef GAMMA_SPIKE_COUNT_EN
  logic [1:0][2:0] res_counts;
`endif

  int errors = 0;
  int checks = 0;

  gamma_result_demux #(.Q(2), .NNET(2), .TRES(3), .DEPTH(2)) dut (
    .clk           (clk),
    .rstb          (rstb),
    .grst          (grst),
    .output_spikes (output_spikes),
    .res_ready     (res_ready),
    .res_valid     (res_valid),
    .res_net       (res_net),
    .res_times     (res_times),
    .res_any       (res_any),
    .res_winner    (res_winner),
    .overflow      (overflow),
    .cur_net       (cur_net)
`ifdef GAMMA_SPIKE_COUNT_EN
    ,
    .res_counts    (res_counts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            g;
    logic [1:0]      sp;
    logic            rdy;
    logic            ev;
    logic [0:0]      enet;
    logic [1:0][2:0] etimes;
    logic            eany;
    logic [0:0]      ewin;
    logic            eovf;
    logic [0:0]      ecur;
    logic [1:0][2:0] ecnt;
  } vec_t;

  vec_t vecs [25];

  function automatic vec_t mk(input logic g, input logic [1:0] sp, input logic rdy,
                              input logic ev, input logic enet, input logic [2:0] t1,
                              input logic [2:0] t0, input logic eany, input logic ewin,
                              input logic eovf, input logic ecur, input logic [2:0] c1,
                              input logic [2:0] c0);
    vec_t v;
    v.g = g; v.sp = sp; v.rdy = rdy; v.ev = ev; v.enet = enet;
    v.etimes = {t1, t0}; v.eany = eany; v.ewin = ewin; v.eovf = eovf;
    v.ecur = ecur; v.ecnt = {c1, c0};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic enet,
                         input logic [5:0] etimes, input logic eany, input logic ewin,
                         input logic eovf, input logic ecur, input logic [5:0] ecnt);
    chk({tag, ".valid"},    32'(res_valid),  32'(ev));
    chk({tag, ".net"},      32'(res_net),    32'(enet));
    chk({tag, ".times"},    32'(res_times),  32'(etimes));
    chk({tag, ".any"},      32'(res_any),    32'(eany));
    chk({tag, ".winner"},   32'(res_winner), 32'(ewin));
    chk({tag, ".overflow"}, 32'(overflow),   32'(eovf));
    chk({tag, ".cur_net"},  32'(cur_net),    32'(ecur));
`ifdef GAMMA_SPIKE_COUNT_EN
    chk({tag, ".counts"},   32'(res_counts), 32'(ecnt));
`else
    if (ecnt != ecnt) $display("unreachable");
`endif
  endtask

  task automatic drive(input logic g, input logic [1:0] sp, input logic rdy);
    grst = g; output_spikes = sp; res_ready = rdy;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Expectations are the outputs sampled after each edge; times/counts are {n1, n0}.
    //                g  sp     rdy ev net t1 t0 any win ovf cur c1 c0
    vecs[0]  = mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // n1 at t=2
    vecs[3]  = mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // n0 at t=4
    vecs[5]  = mk(1, 2'b00, 1, 1, 0, 2, 4, 1, 1, 0, 1, 1, 1);
    vecs[6]  = mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); // popped
    vecs[7]  = mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[8]  = mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[9]  = mk(0, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); // both at t=3
    vecs[10] = mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[11] = mk(0, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); // n0 again at t=5
    vecs[12] = mk(1, 2'b00, 1, 1, 1, 3, 3, 1, 0, 0, 0, 1, 2);
    vecs[13] = mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk(1, 2'b00, 1, 1, 0, 7, 7, 0, 0, 0, 1, 0, 0); // empty gamma
    vecs[15] = mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 16; i <= 21; i++)
      vecs[i] = mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[22] = mk(0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); // n1, t saturated at 6
    vecs[23] = mk(1, 2'b00, 1, 1, 1, 6, 7, 1, 1, 0, 0, 1, 0);
    vecs[24] = mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    rstb = 1'b0;
    drive(0, 2'b00, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 6'd0, 0, 0, 0, 0, 6'd0);
    rstb = 1'b1;
    #1;
    chk_all("idle", 0, 0, 6'd0, 0, 0, 0, 0, 6'd0);

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].g, vecs[i].sp, vecs[i].rdy);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].enet, vecs[i].etimes,
              vecs[i].eany, vecs[i].ewin, vecs[i].eovf, vecs[i].ecur, vecs[i].ecnt);
    end

    // Overflow: three commits with ready low (second is back-to-back and empty).
    drive(0, 2'b01, 0); step();                       // n0 at t=1
    chk_all("ovf_pre", 0, 0, 6'd0, 0, 0, 0, 0, 6'd0);
    drive(1, 2'b00, 0); step();
    chk_all("ovf_c1", 1, 0, {3'd7, 3'd1}, 1, 0, 0, 1, {3'd0, 3'd1});
    drive(1, 2'b00, 0); step();
    chk_all("ovf_c2", 1, 0, {3'd7, 3'd1}, 1, 0, 0, 0, {3'd0, 3'd1});
    drive(1, 2'b00, 0); step();
    chk_all("ovf_c3", 1, 0, {3'd7, 3'd1}, 1, 0, 1, 1, {3'd0, 3'd1});
    drive(0, 2'b00, 1); step();
    chk_all("ovf_pop1", 1, 1, {3'd7, 3'd7}, 0, 0, 1, 1, 6'd0);
    step();
    chk_all("ovf_pop2", 0, 0, 6'd0, 0, 0, 1, 1, 6'd0);

    // Async reset clears the sticky overflow without a clock edge.
    rstb = 1'b0;
    drive(0, 2'b00, 0);
    #2;
    chk_all("rst_async1", 0, 0, 6'd0, 0, 0, 0, 0, 6'd0);
    @(posedge clk);
    #1;
    rstb = 1'b1;

    // Full FIFO with a simultaneous push and pop: no drop.
    drive(1, 2'b00, 0); step();
    chk_all("sim_c1", 1, 0, {3'd7, 3'd7}, 0, 0, 0, 1, 6'd0);
    drive(1, 2'b00, 0); step();
    chk_all("sim_c2", 1, 0, {3'd7, 3'd7}, 0, 0, 0, 0, 6'd0);
    drive(1, 2'b00, 1); step();
    chk_all("sim_pushpop", 1, 1, {3'd7, 3'd7}, 0, 0, 0, 1, 6'd0);
    drive(0, 2'b00, 1); step();
    chk_all("sim_pop", 1, 0, {3'd7, 3'd7}, 0, 0, 0, 1, 6'd0);
    drive(0, 2'b01, 0); step();
    chk_all("sim_hold", 1, 0, {3'd7, 3'd7}, 0, 0, 0, 1, 6'd0);

    // Mid-gamma async reset with a non-empty FIFO.
    rstb = 1'b0;
    #1;
    chk_all("rst_async2", 0, 0, 6'd0, 0, 0, 0, 0, 6'd0);
    step();
    rstb = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
